// File: rtl/ddr3_wb_bridge.sv
// Wishbone classic slave that turns sequential-address bus traffic into read and
// write sessions against the DDR3 controller's ping-pong FIFOs.
module ddr3_wb_bridge #(
    parameter int TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        i_wbs_cyc,
    input  logic        i_wbs_stb,
    input  logic        i_wbs_we,
    input  logic [31:0] i_wbs_adr,
    input  logic [31:0] i_wbs_dat,
    output logic [31:0] o_wbs_dat,
    output logic        o_wbs_ack,
    output logic        o_err,

    input  logic        calibration_done,
    output logic [27:0] address,
    output logic        write_en,
    output logic        read_en,

    input  logic [1:0]  if_write_ready,
    output logic [1:0]  if_write_activate,
    input  logic [23:0] if_write_fifo_size,
    output logic        if_write_strobe,
    output logic [31:0] if_write_data,
    input  logic        if_starved,

    input  logic        of_read_ready,
    output logic        of_read_activate,
    input  logic [23:0] of_read_size,
    output logic        of_read_strobe,
    input  logic [31:0] of_read_data
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] W_ACQ   = 3'd1;
    localparam logic [2:0] W_DATA  = 3'd2;
    localparam logic [2:0] W_FLUSH = 3'd3;
    localparam logic [2:0] R_ACQ   = 3'd4;
    localparam logic [2:0] R_DATA  = 3'd5;
    localparam logic [2:0] R_END   = 3'd6;

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    logic [2:0]    state;
    logic [27:0]   next_adr;
    logic [23:0]   wcount;
    logic [23:0]   rcount;
    logic [TW-1:0] tcount;

    logic          req;
    logic          adr_hit;
    logic          w_full;
    logic          r_done;
    logic          w_svc;
    logic          r_svc;
    logic          t_fire;
    logic          adr_unused;

    // The ack cycle masks the strobe so a classic master holding stb is not re-serviced.
    assign req        = i_wbs_cyc & i_wbs_stb & ~o_wbs_ack;
    assign adr_hit    = (i_wbs_adr[27:0] == next_adr);
    assign w_full     = (wcount >= if_write_fifo_size);
    assign r_done     = (rcount >= of_read_size);
    assign w_svc      = (state == W_DATA) & ~w_full & req & i_wbs_we & adr_hit;
    assign r_svc      = (state == R_DATA) & ~r_done & req & ~i_wbs_we & adr_hit;
    assign t_fire     = req & ~w_svc & ~r_svc & (tcount == T_LAST);
    assign adr_unused = ^i_wbs_adr[31:28];

    always_ff @(posedge clk) begin
        if (rst) begin
            tcount <= '0;
        end else if (req && !w_svc && !r_svc && !t_fire) begin
            tcount <= tcount + 1'b1;
        end else begin
            tcount <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            next_adr          <= '0;
            wcount            <= '0;
            rcount            <= '0;
            address           <= '0;
            write_en          <= 1'b0;
            read_en           <= 1'b0;
            if_write_activate <= 2'b00;
            if_write_strobe   <= 1'b0;
            if_write_data     <= '0;
            of_read_activate  <= 1'b0;
            of_read_strobe    <= 1'b0;
            o_wbs_dat         <= '0;
            o_wbs_ack         <= 1'b0;
            o_err             <= 1'b0;
        end else begin
            o_wbs_ack       <= 1'b0;
            if_write_strobe <= 1'b0;
            of_read_strobe  <= 1'b0;

            // A stalled request is answered with an error ack; the session itself is left alone.
            if (t_fire) begin
                o_wbs_ack <= 1'b1;
                o_wbs_dat <= '0;
                o_err     <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (calibration_done && req) begin
                            if (i_wbs_we) begin
                                if (if_starved) begin
                                    address  <= i_wbs_adr[27:0];
                                    next_adr <= i_wbs_adr[27:0];
                                    write_en <= 1'b1;
                                    state    <= W_ACQ;
                                end
                            end else begin
                                address  <= i_wbs_adr[27:0];
                                next_adr <= i_wbs_adr[27:0];
                                read_en  <= 1'b1;
                                state    <= R_ACQ;
                            end
                        end
                    end

                    W_ACQ: begin
                        if (!i_wbs_cyc) begin
                            write_en <= 1'b0;
                            state    <= W_FLUSH;
                        end else if (if_write_ready[0]) begin
                            if_write_activate <= 2'b01;
                            wcount            <= '0;
                            state             <= W_DATA;
                        end else if (if_write_ready[1]) begin
                            if_write_activate <= 2'b10;
                            wcount            <= '0;
                            state             <= W_DATA;
                        end
                    end

                    W_DATA: begin
                        if (w_full) begin
                            if_write_activate <= 2'b00;
                            state             <= W_ACQ;
                        end else if (!i_wbs_cyc || (req && (!i_wbs_we || !adr_hit))) begin
                            // Releasing the buffer commits whatever was pushed so far.
                            if_write_activate <= 2'b00;
                            write_en          <= 1'b0;
                            state             <= W_FLUSH;
                        end else if (w_svc) begin
                            if_write_data   <= i_wbs_dat;
                            if_write_strobe <= 1'b1;
                            o_wbs_ack       <= 1'b1;
                            wcount          <= wcount + 24'd1;
                            next_adr        <= next_adr + 28'd1;
                        end
                    end

                    W_FLUSH: begin
                        write_en <= 1'b0;
                        if (if_starved) begin
                            state <= IDLE;
                        end
                    end

                    R_ACQ: begin
                        if (!i_wbs_cyc) begin
                            read_en          <= 1'b0;
                            of_read_activate <= 1'b0;
                            state            <= R_END;
                        end else if (of_read_ready) begin
                            of_read_activate <= 1'b1;
                            rcount           <= '0;
                            state            <= R_DATA;
                        end
                    end

                    R_DATA: begin
                        if (r_done) begin
                            of_read_activate <= 1'b0;
                            state            <= R_ACQ;
                        end else if (!i_wbs_cyc || (req && (i_wbs_we || !adr_hit))) begin
                            read_en          <= 1'b0;
                            of_read_activate <= 1'b0;
                            state            <= R_END;
                        end else if (r_svc) begin
                            o_wbs_dat      <= of_read_data;
                            of_read_strobe <= 1'b1;
                            o_wbs_ack      <= 1'b1;
                            rcount         <= rcount + 24'd1;
                            next_adr       <= next_adr + 28'd1;
                        end
                    end

                    // One quiet cycle lets the controller drop any prefetched read data.
                    R_END: begin
                        read_en          <= 1'b0;
                        of_read_activate <= 1'b0;
                        state            <= IDLE;
                    end

                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ddr3_wb_bridge.sv
// Self-checking bench for ddr3_wb_bridge: a Wishbone master, a small DDR3
// controller FIFO model and a session-level reference model.
module tb_ddr3_wb_bridge;

    localparam int TO    = 16;
    localparam int WSIZE = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_wbs_cyc, i_wbs_stb, i_wbs_we;
    logic [31:0] i_wbs_adr, i_wbs_dat, o_wbs_dat;
    logic        o_wbs_ack, o_err;
    logic        calibration_done;
    logic [27:0] address;
    logic        write_en, read_en;
    logic [1:0]  if_write_ready, if_write_activate;
    logic [23:0] if_write_fifo_size;
    logic        if_write_strobe;
    logic [31:0] if_write_data;
    logic        if_starved;
    logic        of_read_ready, of_read_activate;
    logic [23:0] of_read_size;
    logic        of_read_strobe;
    logic [31:0] of_read_data;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ddr3_wb_bridge #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .i_wbs_cyc(i_wbs_cyc), .i_wbs_stb(i_wbs_stb), .i_wbs_we(i_wbs_we),
        .i_wbs_adr(i_wbs_adr), .i_wbs_dat(i_wbs_dat), .o_wbs_dat(o_wbs_dat),
        .o_wbs_ack(o_wbs_ack), .o_err(o_err),
        .calibration_done(calibration_done), .address(address),
        .write_en(write_en), .read_en(read_en),
        .if_write_ready(if_write_ready), .if_write_activate(if_write_activate),
        .if_write_fifo_size(if_write_fifo_size), .if_write_strobe(if_write_strobe),
        .if_write_data(if_write_data), .if_starved(if_starved),
        .of_read_ready(of_read_ready), .of_read_activate(of_read_activate),
        .of_read_size(of_read_size), .of_read_strobe(of_read_strobe),
        .of_read_data(of_read_data)
    );

    // Controller input FIFO: a released buffer stays busy for a few cycles while it drains.
    logic [2:0] busy0, busy1;
    always @(posedge clk) begin
        if (rst) begin
            busy0 <= 3'd0;
            busy1 <= 3'd0;
        end else begin
            busy0 <= if_write_activate[0] ? 3'd4 : ((busy0 != 3'd0) ? busy0 - 3'd1 : 3'd0);
            busy1 <= if_write_activate[1] ? 3'd4 : ((busy1 != 3'd0) ? busy1 - 3'd1 : 3'd0);
        end
    end
    assign if_write_ready     = {(busy1 == 3'd0) && !if_write_activate[1],
                                 (busy0 == 3'd0) && !if_write_activate[0]};
    assign if_starved         = (if_write_activate == 2'b00) && (busy0 == 3'd0) && (busy1 == 3'd0);
    assign if_write_fifo_size = 24'(WSIZE);

    // Controller output FIFO: one preloaded buffer popped by of_read_strobe.
    logic [31:0] rbuf [8];
    int          rsize = 0;
    logic        rload = 1'b0;
    logic        have_buf;
    logic [3:0]  ridx;
    int          rpops = 0;
    always @(posedge clk) begin
        if (rst) begin
            have_buf <= 1'b0;
            ridx     <= 4'd0;
        end else if (rload) begin
            have_buf <= 1'b1;
            ridx     <= 4'd0;
        end else if (of_read_strobe && have_buf) begin
            ridx <= ridx + 4'd1;
            if (32'(ridx) + 1 == rsize) have_buf <= 1'b0;
        end
        if (of_read_strobe) rpops <= rpops + 1;
    end
    assign of_read_ready = have_buf && !of_read_activate;
    assign of_read_size  = 24'(rsize);
    assign of_read_data  = rbuf[ridx[2:0]];

    // Monitor: pushed words, released buffers (bit and word count), enable anomalies.
    logic [31:0] wr_q [$];
    int          ch_words [$];
    logic [1:0]  ch_bits [$];
    logic [1:0]  last_act = 2'b00;
    int          cur_words = 0;
    int          we_bad = 0;
    int          we_low = 0;
    always @(posedge clk) begin
        if (last_act != 2'b00 && if_write_activate != last_act) begin
            ch_words.push_back(cur_words);
            ch_bits.push_back(last_act);
            cur_words <= if_write_strobe ? 1 : 0;
        end else if (if_write_strobe) begin
            cur_words <= cur_words + 1;
        end
        last_act <= if_write_activate;
        if (if_write_strobe) begin
            wr_q.push_back(if_write_data);
            if (!write_en) we_bad <= we_bad + 1;
        end
        if (i_wbs_cyc && !write_en) we_low <= we_low + 1;
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wb_xfer(input logic we, input logic [27:0] adr, input logic [31:0] dat,
                           output logic [31:0] rdat, output logic ok, output int lat);
        i_wbs_cyc = 1'b1;
        i_wbs_stb = 1'b1;
        i_wbs_we  = we;
        i_wbs_adr = {4'($urandom), adr};
        i_wbs_dat = dat;
        ok   = 1'b0;
        rdat = '0;
        lat  = 0;
        while (!ok && lat < 64) begin
            @(posedge clk);
            #1;
            lat++;
            if (o_wbs_ack) begin
                ok   = 1'b1;
                rdat = o_wbs_dat;
            end
        end
        i_wbs_stb = 1'b0;
    endtask

    task automatic wb_end();
        i_wbs_cyc = 1'b0;
        i_wbs_stb = 1'b0;
        i_wbs_we  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(3);
        checks++;
        if ({o_wbs_ack, o_err, write_en, read_en, if_write_activate, if_write_strobe,
             of_read_activate, of_read_strobe} !== 9'd0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: got %b, required 0", {o_wbs_ack, o_err, write_en, read_en,
                     if_write_activate, if_write_strobe, of_read_activate, of_read_strobe});
        end
        checks++;
        if (address !== 28'd0 || o_wbs_dat !== 32'd0 || if_write_data !== 32'd0) begin
            errors++;
            $display("[TB] FAIL reset_data: got adr=%h rdat=%h wdat=%h, required all 0",
                     address, o_wbs_dat, if_write_data);
        end
        rst = 1'b0;
        idle(2);
    endtask

    // Sequential write of n words in one cyc; buffers fill in chunks of WSIZE, alternating bits.
    task automatic test_write_seq(input string name, input logic [27:0] base, input int n);
        logic [31:0] exp_q [$];
        logic [31:0] dat, rd;
        logic        ok;
        int          lat, exp_lat, d0, c0, we0, n_full, n_rem, n_ch, exp_w;
        logic [1:0]  exp_b;
        d0  = wr_q.size();
        c0  = ch_words.size();
        we0 = we_bad;
        for (int i = 0; i < n; i++) begin
            dat = $urandom;
            exp_q.push_back(dat);
            wb_xfer(1'b1, base + 28'(i), dat, rd, ok, lat);
            exp_lat = (i % WSIZE == 0) ? 3 : 2;
            checks++;
            if (!ok || lat != exp_lat) begin
                errors++;
                $display("[TB] FAIL %s ack word %0d: got ack=%0b after %0d cycles, required ack after %0d",
                         name, i, ok, lat, exp_lat);
            end
        end
        wb_end();
        idle(12);
        checks++;
        if (address !== base) begin
            errors++;
            $display("[TB] FAIL %s address: got %h, required %h", name, address, base);
        end
        checks++;
        if (wr_q.size() - d0 != n) begin
            errors++;
            $display("[TB] FAIL %s strobes: got %0d, required %0d", name, wr_q.size() - d0, n);
        end else begin
            for (int i = 0; i < n; i++) begin
                checks++;
                if (wr_q[d0 + i] !== exp_q[i]) begin
                    errors++;
                    $display("[TB] FAIL %s data %0d: got %h, required %h", name, i, wr_q[d0 + i], exp_q[i]);
                end
            end
        end
        n_full = n / WSIZE;
        n_rem  = n % WSIZE;
        n_ch   = n_full + ((n_rem > 0) ? 1 : 0);
        checks++;
        if (ch_words.size() - c0 != n_ch) begin
            errors++;
            $display("[TB] FAIL %s buffers: got %0d released, required %0d", name, ch_words.size() - c0, n_ch);
        end else begin
            for (int k = 0; k < n_ch; k++) begin
                exp_w = (k < n_full) ? WSIZE : n_rem;
                exp_b = (k % 2 == 1) ? 2'b10 : 2'b01;
                checks++;
                if (ch_words[c0 + k] != exp_w || ch_bits[c0 + k] !== exp_b) begin
                    errors++;
                    $display("[TB] FAIL %s buffer %0d: got bit=%b words=%0d, required bit=%b words=%0d",
                             name, k, ch_bits[c0 + k], ch_words[c0 + k], exp_b, exp_w);
                end
            end
        end
        checks++;
        if (we_bad != we0 || write_en !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s write_en: got %0d strobes without it, final %b, required 0 and 0",
                     name, we_bad - we0, write_en);
        end
    endtask

    task automatic test_read_seq(input string name, input logic [27:0] base, input int n, input logic rnd);
        logic [31:0] rd;
        logic        ok;
        int          lat, p0, exp_lat;
        rsize = n + $urandom_range(0, 2);
        if (rsize > 8) rsize = 8;
        for (int i = 0; i < rsize; i++) rbuf[i] = rnd ? $urandom : 32'hA0 + 32'(i);
        rload = 1'b1;
        idle(1);
        rload = 1'b0;
        p0 = rpops;
        for (int i = 0; i < n; i++) begin
            wb_xfer(1'b0, base + 28'(i), 32'd0, rd, ok, lat);
            exp_lat = (i == 0) ? 3 : 2;
            checks++;
            if (!ok || rd !== rbuf[i] || lat != exp_lat || read_en !== 1'b1) begin
                errors++;
                $display("[TB] FAIL %s word %0d: got ack=%0b data=%h lat=%0d read_en=%b, required ack data=%h lat=%0d read_en=1",
                         name, i, ok, rd, lat, read_en, rbuf[i], exp_lat);
            end
        end
        wb_end();
        idle(4);
        checks++;
        if (read_en !== 1'b0 || of_read_activate !== 1'b0 || address !== base) begin
            errors++;
            $display("[TB] FAIL %s end: got read_en=%b act=%b adr=%h, required 0 0 %h",
                     name, read_en, of_read_activate, address, base);
        end
        checks++;
        if (rpops - p0 != n) begin
            errors++;
            $display("[TB] FAIL %s pops: got %0d, required %0d", name, rpops - p0, n);
        end
        idle(4);
    endtask

    task automatic test_write_single_buffer();
        test_write_seq("write4", 28'h100, 4);
    endtask

    task automatic test_write_two_buffers();
        test_write_seq("write70", 28'($urandom), 70);
    endtask

    task automatic test_read();
        test_read_seq("read3", 28'h40, 3, 1'b0);
    endtask

    task automatic test_wrap();
        test_write_seq("wrap", 28'hFFFFFFE, 4);
    endtask

    task automatic test_mismatch();
        logic [27:0] adrs [3];
        logic [31:0] dat [3];
        logic [31:0] rd;
        logic        ok;
        int          lat, d0, c0, low0, nok;
        adrs[0] = 28'h10;
        adrs[1] = 28'h11;
        adrs[2] = 28'h80;
        d0   = wr_q.size();
        c0   = ch_words.size();
        low0 = 0;
        nok  = 0;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) low0 = we_low;
            dat[i] = $urandom;
            wb_xfer(1'b1, adrs[i], dat[i], rd, ok, lat);
            if (!ok) nok++;
        end
        wb_end();
        idle(12);
        checks++;
        if (nok != 0 || address !== 28'h80) begin
            errors++;
            $display("[TB] FAIL mismatch acks: got %0d missing, adr=%h, required 0 missing, adr=080", nok, address);
        end
        checks++;
        if (we_low - low0 == 0) begin
            errors++;
            $display("[TB] FAIL mismatch write_en drop: got 0 low cycles, required at least 1");
        end
        checks++;
        if (wr_q.size() - d0 != 3 || wr_q[d0] !== dat[0] || wr_q[d0 + 1] !== dat[1] || wr_q[d0 + 2] !== dat[2]) begin
            errors++;
            $display("[TB] FAIL mismatch data: got %0d words, required 3 words %h %h %h",
                     wr_q.size() - d0, dat[0], dat[1], dat[2]);
        end
        checks++;
        if (ch_words.size() - c0 != 2 || ch_words[c0] != 2 || ch_words[c0 + 1] != 1 ||
            ch_bits[c0] !== 2'b01 || ch_bits[c0 + 1] !== 2'b01) begin
            errors++;
            $display("[TB] FAIL mismatch buffers: got %0d released, required 2 (bit0 x2, bit0 x1)",
                     ch_words.size() - c0);
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 4; k++) begin
            if ($urandom_range(0, 1) == 1)
                test_write_seq("b2b_write", 28'($urandom), $urandom_range(1, 6));
            else
                test_read_seq("b2b_read", 28'($urandom), $urandom_range(1, 5), 1'b1);
        end
    endtask

    task automatic test_timeout();
        int n;
        checks++;
        if (o_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL timeout pre err: got %b, required 0", o_err);
        end
        calibration_done = 1'b0;
        idle(2);
        i_wbs_cyc = 1'b1;
        i_wbs_stb = 1'b1;
        i_wbs_we  = 1'b0;
        i_wbs_adr = $urandom;
        n = 0;
        while (n < 64 && !o_wbs_ack) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n != TO || o_wbs_dat !== 32'd0 || o_err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL timeout ack: got after %0d cycles data=%h err=%b, required %0d cycles data=0 err=1",
                     n, o_wbs_dat, o_err, TO);
        end
        wb_end();
        idle(3);
        checks++;
        if (o_err !== 1'b1 || read_en !== 1'b0) begin
            errors++;
            $display("[TB] FAIL timeout sticky: got err=%b read_en=%b, required 1 0", o_err, read_en);
        end
        calibration_done = 1'b1;
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        logic        ok;
        int          lat;
        wb_xfer(1'b1, 28'h200, $urandom, rd, ok, lat);
        wb_xfer(1'b1, 28'h201, $urandom, rd, ok, lat);
        i_wbs_stb = 1'b1;
        i_wbs_adr = 32'h202;
        checks++;
        if (write_en !== 1'b1 || if_write_activate !== 2'b01) begin
            errors++;
            $display("[TB] FAIL reset_mid setup: got write_en=%b act=%b, required 1 01", write_en, if_write_activate);
        end
        rst = 1'b1;
        idle(1);
        checks++;
        if ({o_wbs_ack, o_err, write_en, read_en, if_write_activate, if_write_strobe,
             of_read_activate, of_read_strobe} !== 9'd0 || address !== 28'd0) begin
            errors++;
            $display("[TB] FAIL reset_mid outputs: got ctrl=%b adr=%h, required 0", {o_wbs_ack, o_err,
                     write_en, read_en, if_write_activate, if_write_strobe, of_read_activate, of_read_strobe}, address);
        end
        rst = 1'b0;
        wb_end();
        idle(6);
        test_write_seq("post_reset", 28'h300, 1);
    endtask

    initial begin
        rst              = 1'b1;
        calibration_done = 1'b1;
        i_wbs_cyc        = 1'b0;
        i_wbs_stb        = 1'b0;
        i_wbs_we         = 1'b0;
        i_wbs_adr        = '0;
        i_wbs_dat        = '0;
        for (int i = 0; i < 8; i++) rbuf[i] = '0;
        $display("[TB] starting ddr3_wb_bridge bench");
        test_reset();
        test_write_single_buffer();
        test_write_two_buffers();
        test_read();
        test_mismatch();
        test_wrap();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
